// File: rtl/hazard_ctrl.sv
// Load-use/too-late hazard detection and forwarding-select decode for the five-stage core.
// Optional stall-cycle counter is enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl
`ifdef HAZARD_STALL_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Src_D,
    output logic       stall,
    output logic [4:0] ForwardSel_D1,
    output logic [4:0] ForwardSel_D2,
    output logic [4:0] ForwardSel_EA,
    output logic [4:0] ForwardSel_EB,
    output logic [4:0] ForwardSel_MD
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Only the shadow fields that influence an output are kept; Tnew in W is always 0.
    logic [4:0] rs_e, rt_e, a3_e;
    logic [1:0] src_e, tnew_e;
    logic [4:0] rt_m, a3_m;
    logic [1:0] src_m, tnew_m;
    logic [4:0] a3_w;
    logic [1:0] src_w;
    logic [1:0] tnew_d;

    always_comb begin
        tnew_d = 2'd0;
        case (Src_D)
            2'd2:    tnew_d = 2'd1;
            2'd3:    tnew_d = 2'd2;
            default: tnew_d = 2'd0;
        endcase
    end

    function automatic logic stall_op(input logic [4:0] r, input logic [1:0] tuse);
        if (tuse == 2'd3 || r == 5'd0) return 1'b0;
        if (r == a3_e) return tnew_e > tuse;
        if (r == a3_m) return tnew_m > tuse;
        return 1'b0;
    endfunction

    function automatic logic [4:0] sel_d(input logic [4:0] r);
        if (r == 5'd0) return 5'd0;
        if (r == a3_e) return (tnew_e == 2'd0) ? 5'd1 + {3'b000, src_e} : 5'd0;
        if (r == a3_m) return (tnew_m == 2'd0) ? 5'd3 + {3'b000, src_m} : 5'd0;
        if (r == a3_w) return 5'd6 + {3'b000, src_w};
        return 5'd0;
    endfunction

    function automatic logic [4:0] sel_e(input logic [4:0] r);
        if (r == 5'd0) return 5'd0;
        if (r == a3_m) return (tnew_m == 2'd0) ? 5'd1 + {3'b000, src_m} : 5'd0;
        if (r == a3_w) return 5'd4 + {3'b000, src_w};
        return 5'd0;
    endfunction

    function automatic logic [4:0] sel_m(input logic [4:0] r);
        if (r != 5'd0 && r == a3_w) return 5'd1 + {3'b000, src_w};
        return 5'd0;
    endfunction

    assign stall         = stall_op(rs_D, Tuse_rs_D) | stall_op(rt_D, Tuse_rt_D);
    assign ForwardSel_D1 = sel_d(rs_D);
    assign ForwardSel_D2 = sel_d(rt_D);
    assign ForwardSel_EA = sel_e(rs_e);
    assign ForwardSel_EB = sel_e(rt_e);
    assign ForwardSel_MD = sel_m(rt_m);

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_e   <= 5'd0;
            rt_e   <= 5'd0;
            a3_e   <= 5'd0;
            src_e  <= 2'd0;
            tnew_e <= 2'd0;
            rt_m   <= 5'd0;
            a3_m   <= 5'd0;
            src_m  <= 2'd0;
            tnew_m <= 2'd0;
            a3_w   <= 5'd0;
            src_w  <= 2'd0;
        end else begin
            // A stall drops a bubble into E while M and W keep draining.
            if (stall) begin
                rs_e   <= 5'd0;
                rt_e   <= 5'd0;
                a3_e   <= 5'd0;
                src_e  <= 2'd0;
                tnew_e <= 2'd0;
            end else begin
                rs_e   <= rs_D;
                rt_e   <= rt_D;
                a3_e   <= A3_D;
                src_e  <= Src_D;
                tnew_e <= tnew_d;
            end
            rt_m   <= rt_e;
            a3_m   <= a3_e;
            src_m  <= src_e;
            tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
            a3_w   <= a3_m;
            src_w  <= src_m;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios then random instruction streams
// compared against a stage-indexed reference model of the in-flight instructions.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic [4:0] a3;
        logic [1:0] src;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Src_D;
    logic       stall;
    logic [4:0] ForwardSel_D1, ForwardSel_D2, ForwardSel_EA, ForwardSel_EB, ForwardSel_MD;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .rs_D          (rs_D),
        .rt_D          (rt_D),
        .Tuse_rs_D     (Tuse_rs_D),
        .Tuse_rt_D     (Tuse_rt_D),
        .A3_D          (A3_D),
        .Src_D         (Src_D),
        .stall         (stall),
        .ForwardSel_D1 (ForwardSel_D1),
        .ForwardSel_D2 (ForwardSel_D2),
        .ForwardSel_EA (ForwardSel_EA),
        .ForwardSel_EB (ForwardSel_EB),
        .ForwardSel_MD (ForwardSel_MD)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: instructions in flight, index 0 = E, 1 = M, 2 = W.
    instr_t pipe [3];
    instr_t cur_d;
    bit     exp_stall;
    int     exp_cnt;

    function automatic int tnew_at(int src, int k);
        int base;
        base = (src == 3) ? 2 : (src == 2) ? 1 : 0;
        return (base > k) ? base - k : 0;
    endfunction

    function automatic int nearest(int r, int first);
        if (r == 0) return -1;
        for (int k = first; k < 3; k++)
            if (int'(pipe[k].a3) == r) return k;
        return -1;
    endfunction

    function automatic int fwd(int r, int first, int b0, int b1, int b2);
        int k;
        k = nearest(r, first);
        if (k < 0) return 0;
        if (tnew_at(int'(pipe[k].src), k) != 0) return 0;
        return ((k == 0) ? b0 : (k == 1) ? b1 : b2) + int'(pipe[k].src);
    endfunction

    function automatic bit stall_op(int r, int tu);
        int k;
        if (tu == 3) return 1'b0;
        k = nearest(r, 0);
        if (k < 0 || k == 2) return 1'b0;
        return tnew_at(int'(pipe[k].src), k) > tu;
    endfunction

    function automatic instr_t mk(int rs, int rt, int turs, int turt, int a3, int src);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.tu_rs = 2'(turs); i.tu_rt = 2'(turt);
        i.a3 = 5'(a3); i.src = 2'(src);
        return i;
    endfunction

    task automatic eval_d(input instr_t i, input bit rst);
        cur_d = i;
        rs_D = i.rs; rt_D = i.rt; Tuse_rs_D = i.tu_rs; Tuse_rt_D = i.tu_rt;
        A3_D = i.a3; Src_D = i.src; reset = rst;
        #1;
        exp_stall = stall_op(int'(i.rs), int'(i.tu_rs)) | stall_op(int'(i.rt), int'(i.tu_rt));
        check("stall", 32'(stall), 32'(exp_stall));
        check("sel_d1", 32'(ForwardSel_D1), 32'(fwd(int'(i.rs), 0, 1, 3, 6)));
        check("sel_d2", 32'(ForwardSel_D2), 32'(fwd(int'(i.rt), 0, 1, 3, 6)));
        check("sel_ea", 32'(ForwardSel_EA), 32'(fwd(int'(pipe[0].rs), 1, 0, 1, 4)));
        check("sel_eb", 32'(ForwardSel_EB), 32'(fwd(int'(pipe[0].rt), 1, 0, 1, 4)));
        check("sel_md", 32'(ForwardSel_MD), 32'(fwd(int'(pipe[1].rt), 2, 0, 0, 1)));
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'(exp_cnt));
`endif
    endtask

    task automatic tick(input bit rst);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            exp_cnt = 0;
        end else begin
            if (exp_stall) exp_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = exp_stall ? instr_t'('0) : cur_d;
        end
        @(negedge clk);
    endtask

    instr_t nop, ins;
    bit     rnd_rst;

    initial begin
        nop = mk(0, 0, 3, 3, 0, 0);
        exp_stall = 1'b0;
        rs_D = '0; rt_D = '0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3; A3_D = '0; Src_D = '0;
        reset = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        exp_cnt = 0;
        @(negedge clk);

        eval_d(nop, 1'b0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_d1", 32'(ForwardSel_D1), 32'd0);
        tick(1'b0);

        // lw $8 then addu rs=8 Tuse 1
        eval_d(mk(0, 0, 3, 3, 8, 3), 1'b0); tick(1'b0);
        eval_d(mk(8, 0, 1, 3, 9, 2), 1'b0); check("lw_use_stall", 32'(stall), 32'd1); tick(1'b0);
        eval_d(mk(8, 0, 1, 3, 9, 2), 1'b0); check("lw_use_release", 32'(stall), 32'd0); tick(1'b0);
        eval_d(nop, 1'b0); check("lw_use_ea", 32'(ForwardSel_EA), 32'd7); tick(1'b0);

        // jal then jr $31
        eval_d(mk(0, 0, 3, 3, 31, 0), 1'b0); tick(1'b0);
        eval_d(mk(31, 0, 0, 3, 0, 0), 1'b0);
        check("jr_stall", 32'(stall), 32'd0);
        check("jr_d1", 32'(ForwardSel_D1), 32'd1);
        tick(1'b0);

        // addu $3 then beq rs=3
        eval_d(mk(0, 0, 3, 3, 3, 2), 1'b0); tick(1'b0);
        eval_d(mk(3, 0, 0, 3, 0, 0), 1'b0); check("beq_stall", 32'(stall), 32'd1); tick(1'b0);
        eval_d(mk(3, 0, 0, 3, 0, 0), 1'b0);
        check("beq_release", 32'(stall), 32'd0);
        check("beq_d1", 32'(ForwardSel_D1), 32'd5);
        tick(1'b0);

        // lw $5 then sw rt=5 Tuse 2
        eval_d(mk(0, 0, 3, 3, 5, 3), 1'b0); tick(1'b0);
        eval_d(mk(0, 5, 1, 2, 0, 0), 1'b0); check("sw_stall", 32'(stall), 32'd0); tick(1'b0);
        eval_d(nop, 1'b0); tick(1'b0);
        eval_d(nop, 1'b0); check("sw_md", 32'(ForwardSel_MD), 32'd4); tick(1'b0);

        // writes to $0 never forward or stall
        eval_d(mk(0, 0, 3, 3, 0, 1), 1'b0); tick(1'b0);
        eval_d(mk(0, 0, 0, 0, 0, 0), 1'b0);
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_d1", 32'(ForwardSel_D1), 32'd0);
        check("r0_d2", 32'(ForwardSel_D2), 32'd0);
        tick(1'b0);

        // three stall cycles from a clean reset, then reset in the middle of a stall
        eval_d(nop, 1'b1); tick(1'b1);
        eval_d(mk(0, 0, 3, 3, 8, 3), 1'b0); tick(1'b0);
        for (int n = 0; n < 3; n++) begin
            eval_d(mk(8, 0, 0, 3, 3, 2), 1'b0); tick(1'b0);
        end
        eval_d(mk(3, 0, 0, 3, 4, 2), 1'b0); check("cnt_seq_stall", 32'(stall), 32'd1); tick(1'b0);
        eval_d(mk(3, 0, 0, 3, 4, 2), 1'b0);
`ifdef HAZARD_STALL_CNT_EN
        check("cnt_three", stall_cnt, 32'd3);
`endif
        tick(1'b0);
        eval_d(mk(4, 4, 0, 0, 0, 0), 1'b1); check("rst_during_stall", 32'(stall), 32'd1); tick(1'b1);
        eval_d(mk(4, 4, 0, 0, 0, 0), 1'b0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_d1", 32'(ForwardSel_D1), 32'd0);
        check("post_rst_ea", 32'(ForwardSel_EA), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("post_rst_cnt", stall_cnt, 32'd0);
`endif
        tick(1'b0);

        // random stream; a stalled D instruction is held until released
        ins = nop;
        for (int n = 0; n < 3000; n++) begin
            if (!exp_stall)
                ins = mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
            rnd_rst = ($urandom_range(0, 63) == 0);
            eval_d(ins, rnd_rst);
            tick(rnd_rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
